md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched_pkg.sv | 31 +++
 rtl/md_alu.sv | 50 +++++
 rtl/md_sched.sv | 94 +++++++++
 tb/tb_md_sched.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared pipeline definitions for the multiply/divide unit: op encodings,
// default latencies and small op-classification helpers used by decode and md_sched.
package md_sched_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Encodings 0-3 are the multi-cycle arithmetic ops.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op[2:1] == 2'b01);
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational mult/multu/div/divu datapath: {hi,lo} result plus divide-by-zero flag.
// Signed division runs on magnitudes so MIN/-1 and remainder sign fall out naturally.
module md_alu
    import md_sched_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [63:0] res_o,
    output logic        div0_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sgn;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] den_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    assign sgn      = (op_i == OP_DIV);
    assign num      = (sgn && rs_i[31]) ? -rs_i : rs_i;
    assign den      = (sgn && rt_i[31]) ? -rt_i : rt_i;
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign q_mag    = num / den_safe;
    assign r_mag    = num % den_safe;
    assign q_s      = (rs_i[31] ^ rt_i[31]) ? -q_mag : q_mag;
    assign r_s      = rs_i[31] ? -r_mag : r_mag;

    assign div0_o = op_is_div(op_i) && (rt_i == 32'd0);

    always_comb begin
        res_o = 64'd0;
        case (op_i)
            OP_MULT:  res_o = prod_s;
            OP_MULTU: res_o = prod_u;
            OP_DIV:   res_o = {r_s, q_s};
            OP_DIVU:  res_o = {r_mag, q_mag};
            default:  res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler: IDLE/RUN FSM holding the result for MULT_CYC/DIV_CYC cycles.
// Decode stalls combinationally while an md op is in E or still running.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

    md_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [63:0] res_q;
    logic        div0_q;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] alu_res;
    logic        alu_div0;

    md_alu u_alu (
        .op_i   (E_op),
        .rs_i   (E_rs),
        .rt_i   (E_rt),
        .res_o  (alu_res),
        .div0_o (alu_div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= 64'd0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (E_start) begin
                        if (op_is_arith(E_op)) begin
                            res_q   <= alu_res;
                            div0_q  <= alu_div0;
                            cnt_q   <= op_is_div(E_op) ? DIV_LD : MULT_LD;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else if (E_op == OP_MTHI) begin
                            hi_q <= E_rs;
                        end else if (E_op == OP_MTLO) begin
                            lo_q <= E_rs;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        // A zero divisor still costs the full latency but leaves HI/LO intact.
                        if (!div0_q) begin
                            hi_q <= res_q[63:32];
                            lo_q <= res_q[31:0];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign stall = D_md_use & (busy_q | E_start) & ~reset;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: stimulus pushes per-cycle expectations, a negedge monitor compares.
module tb_md_sched;
    import md_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sched dut (
        .clk      (clk),
        .reset    (reset),
        .E_start  (E_start),
        .E_op     (E_op),
        .E_rs     (E_rs),
        .E_rt     (E_rt),
        .D_md_use (D_md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic        busy;
        logic        stall;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          tag_n = 0;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle#%0d: got %h, want %h", nm, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy",  e.tag, {31'd0, busy},  {31'd0, e.busy});
            chk("stall", e.tag, {31'd0, stall}, {31'd0, e.stall});
            chk("hi",    e.tag, hi, e.hi);
            chk("lo",    e.tag, lo, e.lo);
        end
    end

    // One cycle: drive inputs just after the edge, record what the outputs must show this cycle.
    task automatic step(input logic rst, input logic st, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic dmu,
                        input logic eb, input logic es);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        E_start  = st;
        E_op     = op;
        E_rs     = rs;
        E_rt     = rt;
        D_md_use = dmu;
        tag_n++;
        e.tag   = tag_n;
        e.busy  = eb;
        e.stall = es;
        e.hi    = cur_hi;
        e.lo    = cur_lo;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic dmu);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, dmu, 1'b0, 1'b0);
    endtask

    // Issue an arithmetic op, hold D_md_use for its whole life, then commit expected HI/LO.
    task automatic md_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input int n, input logic dmu, input logic [31:0] nh,
                         input logic [31:0] nl, input logic wr);
        step(1'b0, 1'b1, op, rs, rt, dmu, 1'b0, dmu);
        repeat (n) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, dmu, 1'b1, dmu);
        if (wr) begin
            cur_hi = nh;
            cur_lo = nl;
        end
    endtask

    initial begin
        reset = 1'b1; E_start = 1'b0; E_op = 3'd0; E_rs = 32'd0; E_rt = 32'd0; D_md_use = 1'b0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        // In reset: stall suppressed even with start and D_md_use
        step(1'b1, 1'b1, OP_MULT, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);

        // mult accepted on the first edge after reset release; mtlo during last busy cycle ignored
        step(1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1, 1'b1);
        cur_hi = 32'hFFFF_FFFF;
        cur_lo = 32'hFFFF_FFFA;

        // multu starts on the cycle busy drops
        md_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA, 1'b1);
        idle(1'b1);

        // mthi / mtlo in IDLE: one-edge update, no busy
        step(1'b0, 1'b1, OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
        cur_hi = 32'h1234_5678;
        step(1'b0, 1'b1, OP_MTLO, 32'hA5A5_A5A5, 32'd0, 1'b1, 1'b0, 1'b1);
        cur_lo = 32'hA5A5_A5A5;
        idle(1'b0);

        md_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 10, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
        md_op(OP_DIVU, 32'd7, 32'd0, 10, 1'b0, 32'd0, 32'd0, 1'b0);
        md_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000, 1'b1);
        md_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 10, 1'b0, 32'h0000_000F, 32'h0FFF_FFFF, 1'b1);
        md_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b1);
        md_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 5, 1'b0, 32'h4000_0000, 32'd0, 1'b1);
        md_op(OP_DIV,  32'd5, 32'd0, 10, 1'b0, 32'd0, 32'd0, 1'b0);

        // Reserved ops: no state change, stall still follows E_start
        step(1'b0, 1'b1, 3'd6, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 3'd7, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // Reset during cycle t+3 of a div: immediate clear, no late write
        step(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        step(1'b1, 1'b1, OP_MTHI, 32'hFFFF_0000, 32'd0, 1'b1, 1'b0, 1'b0);
        repeat (12) idle(1'b1);

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
